// File: rtl/time_bcd_to_count.sv
// Packed 12-hour BCD time (+AM/PM) to hundredths-of-a-second since midnight.
// Sequential shift-add Horner evaluation with a start/valid/error handshake.
module time_bcd_to_count #(
    parameter int BIT_WIDTH = 24
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic [31:0]          i_Time,
    input  logic                 i_PM,
    output logic [BIT_WIDTH-1:0] o_Count,
    output logic                 o_Valid,
    output logic                 o_Error,
    output logic                 o_Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MAC   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [31:0]          time_q, time_nxt;
    logic                 pm_q, pm_nxt;
    logic [23:0]          acc, acc_nxt;
    logic [2:0]           step, step_nxt;
    logic [BIT_WIDTH-1:0] count_nxt;
    logic                 valid_nxt, error_nxt, busy_nxt;

    function automatic logic [23:0] times6(input logic [23:0] a);
        return (a << 2) + (a << 1);
    endfunction

    function automatic logic [23:0] times10(input logic [23:0] a);
        return (a << 3) + (a << 1);
    endfunction

    // 12-hour value 10*H1 + H0, wide enough that malformed digits cannot wrap into 1..12.
    function automatic logic [7:0] hour12(input logic [31:0] t);
        return ({4'd0, t[31:28]} << 3) + ({4'd0, t[31:28]} << 1) + {4'd0, t[27:24]};
    endfunction

    function automatic logic [23:0] hour24(input logic [7:0] h12, input logic pm);
        logic [23:0] h;
        if (pm)
            h = (h12 == 8'd12) ? 24'd12 : 24'(h12) + 24'd12;
        else
            h = (h12 == 8'd12) ? 24'd0 : 24'(h12);
        return h;
    endfunction

    function automatic logic time_ok(input logic [31:0] t);
        logic       ok;
        logic [7:0] h;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (t[23:20] > 4'd5) ok = 1'b0;
        if (t[15:12] > 4'd5) ok = 1'b0;
        if (t[31:28] > 4'd1) ok = 1'b0;
        h = hour12(t);
        if (h == 8'd0 || h > 8'd12) ok = 1'b0;
        return ok;
    endfunction

    // One mixed-radix Horner step: minutes/seconds tens are base 6, everything else base 10.
    function automatic logic [23:0] mac_step(input logic [23:0] a, input logic [2:0] s,
                                             input logic [31:0] t);
        logic [23:0] r;
        case (s)
            3'd0:    r = times6(a)  + 24'(t[23:20]);
            3'd1:    r = times10(a) + 24'(t[19:16]);
            3'd2:    r = times6(a)  + 24'(t[15:12]);
            3'd3:    r = times10(a) + 24'(t[11:8]);
            3'd4:    r = times10(a) + 24'(t[7:4]);
            default: r = times10(a) + 24'(t[3:0]);
        endcase
        return r;
    endfunction

    always_comb begin
        state_nxt = state;
        time_nxt  = time_q;
        pm_nxt    = pm_q;
        acc_nxt   = acc;
        step_nxt  = step;
        count_nxt = o_Count;
        valid_nxt = 1'b0;
        error_nxt = 1'b0;
        busy_nxt  = o_Busy;

        case (state)
            IDLE: begin
                if (i_Start) begin
                    time_nxt  = i_Time;
                    pm_nxt    = i_PM;
                    busy_nxt  = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!time_ok(time_q)) begin
                    error_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    acc_nxt   = hour24(hour12(time_q), pm_q);
                    step_nxt  = 3'd0;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                acc_nxt  = mac_step(acc, step, time_q);
                step_nxt = step + 3'd1;
                if (step == 3'd5) begin
                    count_nxt = BIT_WIDTH'(acc_nxt);
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state   <= IDLE;
            time_q  <= '0;
            pm_q    <= 1'b0;
            acc     <= '0;
            step    <= '0;
            o_Count <= '0;
            o_Valid <= 1'b0;
            o_Error <= 1'b0;
            o_Busy  <= 1'b0;
        end else begin
            state   <= state_nxt;
            time_q  <= time_nxt;
            pm_q    <= pm_nxt;
            acc     <= acc_nxt;
            step    <= step_nxt;
            o_Count <= count_nxt;
            o_Valid <= valid_nxt;
            o_Error <= error_nxt;
            o_Busy  <= busy_nxt;
        end
    end

endmodule

// File: doc/time_bcd_to_count.md
# time_bcd_to_count

Converts a packed 12-hour BCD time with an AM/PM flag into the linear hundredths-of-a-second count used by the time counter, 0 to 8,639,999 for one day. It sits between the time-set and alarm-set logic and the counter preload and alarm compare paths. It is the inverse of the count-to-display digit conversion. It runs as a multi-cycle, shift-add sequential converter with a start/valid handshake, so no wide multipliers or dividers are built.

## Interface
- BIT_WIDTH, 24, width of o_Count; must be ≥ 24.
- i_Clk  input  1  system clock, the 5 MHz domain; all logic is rising-edge.
- i_Reset  input  1  asynchronous, active-low reset (0 = reset).
- i_Start  input  1  one-cycle conversion request; sampled only when o_Busy = 0.
- i_Time  input  32  packed BCD digits {H1,H0,M1,M0,S1,S0,F1,F0}, 4 bits each, MSB first.
- i_PM  input  1  1 = PM, 0 = AM.
- o_Count  output  BIT_WIDTH  last successful result, hundredths since midnight.
- o_Valid  output  1  one-cycle pulse when o_Count has been updated.
- o_Error  output  1  one-cycle pulse when the request was rejected as invalid.
- o_Busy  output  1  high while a request is in progress.

## Operation
- States: IDLE, CHECK, MAC.
- IDLE
  - If i_Start = 1, latch i_Time and i_PM into holding registers, set o_Busy, and go to CHECK.
  - Inputs are ignored while busy.
- CHECK
  - Validate the latched digits: every digit must be ≤ 9; M1 ≤ 5; S1 ≤ 5; H1 ≤ 1; h12 = 10·H1 + H0 must be in 1..12.
  - On failure: pulse o_Error, clear o_Busy, return to IDLE. o_Count is unchanged.
  - On success: load acc = h24, clear the step counter, and go to MAC.
  - Hour mapping:
    - AM: 12 → 0, otherwise h12.
    - PM: 12 → 12, otherwise h12 + 12.
- MAC: six steps in mixed-radix Horner form, one step per cycle, selected by a 3-bit step counter.
  - acc = acc·6 + M1
  - acc = acc·10 + M0
  - acc = acc·6 + S1
  - acc = acc·10 + S0
  - acc = acc·10 + F1
  - acc = acc·10 + F0
- Arithmetic rules
  - ×10 = (acc<<3) + (acc<<1); ×6 = (acc<<2) + (acc<<1).
  - acc is 24 bits unsigned; no intermediate exceeds 8,639,999, so no overflow is possible.
- On the sixth step: write the result to o_Count, pulse o_Valid, clear o_Busy, and return to IDLE.
- o_Valid and o_Error are mutually exclusive and never asserted together.

## Timing
- Reset (asynchronous, i_Reset = 0): state IDLE; o_Count = 0, o_Valid = 0, o_Error = 0, o_Busy = 0; acc and holding registers cleared.
- Reset mid-conversion aborts the request. No o_Valid or o_Error is produced, and o_Count returns to 0.
- Edge E0: i_Start is sampled with o_Busy = 0. o_Busy is high after E0.
- Edge E1: CHECK completes.
  - Invalid request: o_Error is high for the cycle after E1, and o_Busy is low after E1.
- Edges E2 to E7: the six MAC steps.
- After E7: o_Count holds the new value, o_Valid is high for exactly one cycle, and o_Busy is low.
- Latency: 7 cycles from the start-sampling edge to o_Valid.
- Back-to-back requests: i_Start presented in the o_Valid cycle is accepted at the next edge. The earliest restart is 8 cycles after the previous start.
- i_Start while o_Busy = 1 is dropped, not queued.
- Changes on i_Time or i_PM after E0 have no effect on the request in progress.

## Test plan
- i_Time = 32'h1200_0000, i_PM = 0 (12:00:00.00 AM) → o_Count = 0; o_Valid pulses 7 cycles after the start edge; o_Busy is high for 7 cycles.
- i_Time = 32'h1159_5999, i_PM = 1 → o_Count = 8,639,999. Then 32'h1230_1550, i_PM = 1 → 4,501,550. Then 32'h0100_0000, i_PM = 0 → 360,000.
- Invalid inputs, each → o_Error pulses one cycle after E1, o_Valid never asserts, o_Count keeps its prior value:
  - 32'h1360_0000
  - 32'h0000_0000 (hour 0)
  - 32'h010A_0000
- Hold i_Start high continuously with changing i_Time → requests are accepted only every 8 cycles, and each result matches the i_Time present at its own start edge.
- Drive i_Reset low at E4 of a conversion → all outputs are 0 immediately (asynchronous) and no o_Valid follows. After release, a new request converts correctly.
- Exhaustive sweep over all valid H:M for AM/PM with S = 59, F = 99 → o_Count matches the golden model ((h24·60 + m)·60 + 59)·100 + 99.
